// File: rtl/ppu_pkg.sv
// ppu_pkg: shared definitions for the NES PPU CPU-side register port.
//   - CPU register select codes ($2000-$2007 -> 0..7)
//   - VRAM region decode bounds
//   - $2007 access FSM state type
//   - palette mirror/alias helper
package ppu_pkg;

  // Register selects (CPU A[2:0])
  localparam logic [2:0] REG_CTRL    = 3'd0;
  localparam logic [2:0] REG_MASK    = 3'd1;
  localparam logic [2:0] REG_STATUS  = 3'd2;
  localparam logic [2:0] REG_OAMADDR = 3'd3;
  localparam logic [2:0] REG_OAMDATA = 3'd4;
  localparam logic [2:0] REG_SCROLL  = 3'd5;
  localparam logic [2:0] REG_ADDR    = 3'd6;
  localparam logic [2:0] REG_DATA    = 3'd7;

  // Region decode: below CHR_TOP is pattern space, page PAL_PAGE is palette
  localparam logic [13:0] CHR_TOP  = 14'h2000;
  localparam logic [5:0]  PAL_PAGE = 6'h3F;

  typedef enum logic {
    StIdle,
    StAcc
  } acc_state_e;

  // $3F10/$3F14/$3F18/$3F1C share storage with $3F00/$3F04/$3F08/$3F0C
  function automatic logic [4:0] pal_alias(input logic [4:0] idx);
    return (idx[1:0] == 2'b00) ? {1'b0, idx[3:0]} : idx;
  endfunction

endpackage

// File: rtl/ppu_palram.sv
// ppu_palram: 32x6 palette RAM with mirror aliasing applied on every port.
// Ports:
//   i_clk        clock, write on posedge
//   i_we         write enable
//   i_waddr      write palette index (5b, aliased internally)
//   i_wdata      write colour (6b)
//   i_raddr      scan-out lookup index, o_rdata its colour (combinational)
//   i_cpu_raddr  CPU-side lookup index, o_cpu_rdata its colour (combinational)
// Contents are not reset.
module ppu_palram
  import ppu_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_we,
  input  logic [4:0] i_waddr,
  input  logic [5:0] i_wdata,
  input  logic [4:0] i_raddr,
  output logic [5:0] o_rdata,
  input  logic [4:0] i_cpu_raddr,
  output logic [5:0] o_cpu_rdata
);

  logic [5:0] r_mem [32];

  always_ff @(posedge i_clk) begin
    if (i_we) begin
      r_mem[pal_alias(i_waddr)] <= i_wdata;
    end
  end

  // Asynchronous reads: a write in the same cycle is seen only after the edge
  assign o_rdata     = r_mem[pal_alias(i_raddr)];
  assign o_cpu_rdata = r_mem[pal_alias(i_cpu_raddr)];

endmodule

// File: rtl/ppu_cpuport.sv
// ppu_cpuport: CPU-side register port of the NES PPU.
// Decodes $2000-$2007, owns the VRAM write port, the palette RAM, VBLANK flag and NMI.
// Parameters:
//   MIRROR_V  1 = vertical mirroring (VRAM A10 = v[10]), 0 = horizontal (A10 = v[11])
//   INC_BIG   PPUADDR step when PPUCTRL[2] = 1
// Configuration macro: PPU_SCROLL_EN -- when defined, $2005 writes load scroll_x/scroll_y;
//   otherwise $2005 only toggles the write latch and both scroll outputs are 8'h00.
// Ports:
//   CLK25, RSTn                  clock, async active-low reset
//   cpu_a/cpu_din/cpu_we/cpu_re  CPU register access (one-cycle strobes)
//   cpu_dout                     registered read data, valid the cycle after cpu_re
//   busy                         $2007 access in progress
//   wvaddr/wvdata/wvwe/wvq       nametable VRAM port (wvq valid one cycle after wvaddr)
//   pal_idx/pal_color            scan-out palette lookup (combinational)
//   vbl_set/vbl_clr              VBLANK entry / pre-render pulses
//   bankbg, scroll_x, scroll_y   render controls
//   nmi_n                        active-low NMI level
module ppu_cpuport
  import ppu_pkg::*;
#(
  parameter bit          MIRROR_V = 1'b1,
  parameter int unsigned INC_BIG  = 32
) (
  input  logic        CLK25,
  input  logic        RSTn,
  input  logic [2:0]  cpu_a,
  input  logic [7:0]  cpu_din,
  input  logic        cpu_we,
  input  logic        cpu_re,
  output logic [7:0]  cpu_dout,
  output logic        busy,
  output logic [10:0] wvaddr,
  output logic [7:0]  wvdata,
  output logic        wvwe,
  input  logic [7:0]  wvq,
  input  logic [4:0]  pal_idx,
  output logic [5:0]  pal_color,
  input  logic        vbl_set,
  input  logic        vbl_clr,
  output logic        bankbg,
  output logic [7:0]  scroll_x,
  output logic [7:0]  scroll_y,
  output logic        nmi_n
);

  localparam logic [13:0] IncBig = 14'(INC_BIG);

  acc_state_e  r_state;
  logic        r_inc_big;   // PPUCTRL[2]
  logic        r_bankbg;    // PPUCTRL[4]
  logic        r_nmi_en;    // PPUCTRL[7]
  logic [13:0] r_v;
  logic        r_w;
  logic        r_vblank;
  logic [7:0]  r_rdbuf;
  logic [7:0]  r_dout;
  logic        r_wvwe;
  logic [10:0] r_wvaddr;
  logic [7:0]  r_wvdata;
  logic        r_busy;
  logic        r_acc_rd;    // in-flight access must refill the read buffer
  logic        r_rd_pend;   // wvq is valid this cycle, capture into rdbuf
`ifdef PPU_SCROLL_EN
  logic [7:0]  r_scroll_x;
  logic [7:0]  r_scroll_y;
`endif

  logic        w_data_acc;
  logic        w_rd_status;
  logic        w_is_chr;
  logic        w_is_pal;
  logic        w_is_vram;
  logic [10:0] w_vaddr;
  logic [13:0] w_v_inc;
  logic [7:0]  w_rdbuf_now;
  logic        w_pal_we;
  logic [5:0]  w_pal_cpu;

  // Nametable mirroring. Palette reads shadow VRAM at v-$1000; that subtraction leaves
  // v[11:0] untouched, so the same mapping serves both.
  function automatic logic [10:0] vram_map(input logic [11:0] a);
    return {(MIRROR_V ? a[10] : a[11]), a[9:0]};
  endfunction

  assign w_data_acc  = (cpu_we | cpu_re) & (cpu_a == REG_DATA) & (r_state == StIdle);
  assign w_rd_status = cpu_re & (cpu_a == REG_STATUS);
  assign w_is_chr    = (r_v < CHR_TOP);
  assign w_is_pal    = (r_v[13:8] == PAL_PAGE);
  assign w_is_vram   = ~w_is_chr & ~w_is_pal;
  assign w_vaddr     = vram_map(r_v[11:0]);
  assign w_v_inc     = r_v + (r_inc_big ? IncBig : 14'd1);  // 14-bit sum wraps $3FFF->$0000
  // Forward wvq when a buffer refill lands in the same cycle as the next read
  assign w_rdbuf_now = r_rd_pend ? wvq : r_rdbuf;
  assign w_pal_we    = w_data_acc & cpu_we & w_is_pal;

  ppu_palram u_palram (
    .i_clk       (CLK25),
    .i_we        (w_pal_we),
    .i_waddr     (r_v[4:0]),
    .i_wdata     (cpu_din[5:0]),
    .i_raddr     (pal_idx),
    .o_rdata     (pal_color),
    .i_cpu_raddr (r_v[4:0]),
    .o_cpu_rdata (w_pal_cpu)
  );

  always_ff @(posedge CLK25 or negedge RSTn) begin
    if (!RSTn) begin
      r_state    <= StIdle;
      r_inc_big  <= 1'b0;
      r_bankbg   <= 1'b0;
      r_nmi_en   <= 1'b0;
      r_v        <= '0;
      r_w        <= 1'b0;
      r_vblank   <= 1'b0;
      r_rdbuf    <= '0;
      r_dout     <= '0;
      r_wvwe     <= 1'b0;
      r_wvaddr   <= '0;
      r_wvdata   <= '0;
      r_busy     <= 1'b0;
      r_acc_rd   <= 1'b0;
      r_rd_pend  <= 1'b0;
`ifdef PPU_SCROLL_EN
      r_scroll_x <= '0;
      r_scroll_y <= '0;
`endif
    end else begin
      r_wvwe <= 1'b0;

      if (r_rd_pend) begin
        r_rdbuf   <= wvq;
        r_rd_pend <= 1'b0;
      end

      // clr beats set; a status read in the set cycle still returned the old flag
      if (vbl_clr) begin
        r_vblank <= 1'b0;
      end else if (vbl_set) begin
        r_vblank <= 1'b1;
      end else if (w_rd_status) begin
        r_vblank <= 1'b0;
      end

      if (cpu_we) begin
        case (cpu_a)
          REG_CTRL: begin
            r_inc_big <= cpu_din[2];
            r_bankbg  <= cpu_din[4];
            r_nmi_en  <= cpu_din[7];
          end
          REG_SCROLL: begin
`ifdef PPU_SCROLL_EN
            if (!r_w) begin
              r_scroll_x <= cpu_din;
            end else begin
              r_scroll_y <= cpu_din;
            end
`endif
            r_w <= ~r_w;
          end
          REG_ADDR: begin
            if (!r_w) begin
              r_v[13:8] <= cpu_din[5:0];
            end else begin
              r_v[7:0] <= cpu_din;
            end
            r_w <= ~r_w;
          end
          REG_MASK, REG_OAMADDR, REG_OAMDATA: ;  // accepted, no effect
          default: ;
        endcase
      end

      if (cpu_re) begin
        if (cpu_a == REG_STATUS) begin
          r_dout <= {r_vblank, 7'b0};
          r_w    <= 1'b0;
        end else if (cpu_a != REG_DATA) begin
          r_dout <= 8'h00;
        end
      end

      case (r_state)
        StIdle: begin
          if (w_data_acc) begin
            r_state <= StAcc;
            r_busy  <= 1'b1;
            r_v     <= w_v_inc;
            if (cpu_we) begin
              if (w_is_vram) begin
                r_wvaddr <= w_vaddr;
                r_wvdata <= cpu_din;
                r_wvwe   <= 1'b1;
              end
            end else if (w_is_chr) begin
              r_dout  <= w_rdbuf_now;
              r_rdbuf <= 8'h00;
            end else if (w_is_pal) begin
              r_dout   <= {2'b00, w_pal_cpu};
              r_wvaddr <= w_vaddr;
              r_acc_rd <= 1'b1;
            end else begin
              r_dout   <= w_rdbuf_now;
              r_wvaddr <= w_vaddr;
              r_acc_rd <= 1'b1;
            end
          end
        end
        StAcc: begin
          r_state   <= StIdle;
          r_busy    <= 1'b0;
          r_rd_pend <= r_acc_rd;
          r_acc_rd  <= 1'b0;
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign cpu_dout = r_dout;
  assign busy     = r_busy;
  assign wvaddr   = r_wvaddr;
  assign wvdata   = r_wvdata;
  assign wvwe     = r_wvwe;
  assign bankbg   = r_bankbg;
  assign nmi_n    = ~(r_vblank & r_nmi_en);
`ifdef PPU_SCROLL_EN
  assign scroll_x = r_scroll_x;
  assign scroll_y = r_scroll_y;
`else
  assign scroll_x = 8'h00;
  assign scroll_y = 8'h00;
`endif

endmodule

// File: tb/tb_ppu_cpuport.sv
// Scoreboard bench for ppu_cpuport: stimulus pushes expected VRAM writes and read data into
// queues; a monitor pops and compares whenever wvwe pulses or read data becomes valid.
module tb_ppu_cpuport;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [2:0]  cpu_a = '0;
  logic [7:0]  cpu_din = '0;
  logic        cpu_we = 1'b0;
  logic        cpu_re = 1'b0;
  logic [4:0]  pal_idx = '0;
  logic        vbl_set = 1'b0;
  logic        vbl_clr = 1'b0;
  logic [7:0]  wvq;

  logic [7:0]  cpu_dout, h_cpu_dout;
  logic        busy, h_busy;
  logic [10:0] wvaddr, h_wvaddr;
  logic [7:0]  wvdata, h_wvdata;
  logic        wvwe, h_wvwe;
  logic [5:0]  pal_color, h_pal_color;
  logic        bankbg, h_bankbg;
  logic [7:0]  scroll_x, scroll_y, h_scroll_x, h_scroll_y;
  logic        nmi_n, h_nmi_n;

  always #5 clk = ~clk;

  ppu_cpuport #(.MIRROR_V(1'b1), .INC_BIG(32)) u_dut (
    .CLK25(clk), .RSTn(rst_n), .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_dout(cpu_dout), .busy(busy), .wvaddr(wvaddr), .wvdata(wvdata),
    .wvwe(wvwe), .wvq(wvq), .pal_idx(pal_idx), .pal_color(pal_color), .vbl_set(vbl_set),
    .vbl_clr(vbl_clr), .bankbg(bankbg), .scroll_x(scroll_x), .scroll_y(scroll_y),
    .nmi_n(nmi_n)
  );

  ppu_cpuport #(.MIRROR_V(1'b0), .INC_BIG(32)) u_dut_h (
    .CLK25(clk), .RSTn(rst_n), .cpu_a(cpu_a), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cpu_re(cpu_re), .cpu_dout(h_cpu_dout), .busy(h_busy), .wvaddr(h_wvaddr),
    .wvdata(h_wvdata), .wvwe(h_wvwe), .wvq(wvq), .pal_idx(pal_idx), .pal_color(h_pal_color),
    .vbl_set(vbl_set), .vbl_clr(vbl_clr), .bankbg(h_bankbg), .scroll_x(h_scroll_x),
    .scroll_y(h_scroll_y), .nmi_n(h_nmi_n)
  );

  // Synchronous-read nametable model
  logic [7:0] vram [2048];
  always @(posedge clk) begin
    if (wvwe) vram[wvaddr] <= wvdata;
    wvq <= vram[wvaddr];
  end

  int n_checks = 0;
  int n_pass = 0;

  logic [18:0] exp_wr_q [$];
  string       exp_wr_n [$];
  logic [7:0]  exp_rd_q [$];
  string       exp_rd_n [$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, got, exp);
  endtask

  // Monitor: read data valid the cycle after a sampled cpu_re; VRAM writes on wvwe
  logic rd_seen = 1'b0;
  always @(posedge clk) rd_seen <= cpu_re & rst_n;

  always @(negedge clk) begin
    if (rst_n && wvwe) begin
      if (exp_wr_q.size() == 0) begin
        n_checks++;
        $display("FAIL wr_unexpected: got addr=%h data=%h, expected no write", wvaddr, wvdata);
      end else begin
        check({"wr ", exp_wr_n.pop_front()}, 32'({wvaddr, wvdata}), 32'(exp_wr_q.pop_front()));
      end
    end
    if (rd_seen) begin
      if (exp_rd_q.size() == 0) begin
        n_checks++;
        $display("FAIL rd_unexpected: got dout=%h, expected no read", cpu_dout);
      end else begin
        check({"rd ", exp_rd_n.pop_front()}, 32'(cpu_dout), 32'(exp_rd_q.pop_front()));
      end
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    @(posedge clk); #1;
    cpu_a = a; cpu_din = d; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_we = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input logic [7:0] exp, input string name,
                    input logic setv, input logic clrv);
    exp_rd_q.push_back(exp);
    exp_rd_n.push_back(name);
    @(posedge clk); #1;
    cpu_a = a; cpu_re = 1'b1; vbl_set = setv; vbl_clr = clrv;
    @(posedge clk); #1;
    cpu_re = 1'b0; vbl_set = 1'b0; vbl_clr = 1'b0;
  endtask

  task automatic vwr(input logic [7:0] d, input logic [10:0] addr, input string name);
    exp_wr_q.push_back({addr, d});
    exp_wr_n.push_back(name);
    wr(3'd7, d);
  endtask

  task automatic setaddr(input logic [7:0] hi, input logic [7:0] lo);
    wr(3'd6, hi);
    wr(3'd6, lo);
  endtask

  task automatic vbl_pulse(input logic setv, input logic clrv);
    @(posedge clk); #1;
    vbl_set = setv; vbl_clr = clrv;
    @(posedge clk); #1;
    vbl_set = 1'b0; vbl_clr = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_sx, exp_sy;
`ifdef PPU_SCROLL_EN
    exp_sx = 8'h7B; exp_sy = 8'h3C;
`else
    exp_sx = 8'h00; exp_sy = 8'h00;
`endif

    #3 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_dout", 32'(cpu_dout), 32'h00);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_wvwe", 32'(wvwe), 32'h0);
    check("rst_wvaddr", 32'(wvaddr), 32'h000);
    check("rst_wvdata", 32'(wvdata), 32'h00);
    check("rst_nmi_n", 32'(nmi_n), 32'h1);
    check("rst_bankbg", 32'(bankbg), 32'h0);
    check("rst_scroll", 32'({scroll_x, scroll_y}), 32'h0000);
    rst_n = 1'b1;

    // Basic nametable write and auto-increment by 1
    setaddr(8'h20, 8'h00);
    vwr(8'hAB, 11'h000, "vram_2000");
    vwr(8'hCD, 11'h001, "vram_2001_inc");

    // Mirroring: $2405 -> $405 vertical, $005 horizontal
    setaddr(8'h24, 8'h05);
    vwr(8'h11, 11'h405, "mirror_v");
    check("mirror_h", 32'({h_wvwe, h_wvaddr}), 32'({1'b1, 11'h005}));

    // Buffered reads
    setaddr(8'h23, 8'h00);
    vwr(8'h5A, 11'h300, "vram_2300");
    setaddr(8'h23, 8'h00);
    rd(3'd7, 8'h00, "buf_first", 1'b0, 1'b0);
    rd(3'd7, 8'h5A, "buf_second", 1'b0, 1'b0);

    // Palette aliasing, unbuffered palette read, shadow buffer fill from $2F00
    setaddr(8'h2F, 8'h00);
    vwr(8'h77, 11'h700, "vram_2f00");
    setaddr(8'h3F, 8'h10);
    wr(3'd7, 8'h2C);
    pal_idx = 5'h00; #1;
    check("pal_alias_00", 32'(pal_color), 32'h2C);
    pal_idx = 5'h10; #1;
    check("pal_lookup_10", 32'(pal_color), 32'h2C);
    setaddr(8'h3F, 8'h00);
    rd(3'd7, 8'h2C, "pal_nobuf", 1'b0, 1'b0);
    setaddr(8'h20, 8'h00);
    rd(3'd7, 8'h77, "buf_from_shadow", 1'b0, 1'b0);

    // Palette write and lookup of the same index: old value until the edge
    setaddr(8'h3F, 8'h01);
    wr(3'd7, 8'h0A);
    setaddr(8'h3F, 8'h01);
    pal_idx = 5'h01;
    @(posedge clk); #1;
    cpu_a = 3'd7; cpu_din = 8'h15; cpu_we = 1'b1;
    @(negedge clk);
    check("pal_rw_old", 32'(pal_color), 32'h0A);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    check("pal_rw_new", 32'(pal_color), 32'h15);

    // VBLANK / NMI / status read
    wr(3'd0, 8'h80);
    check("nmi_idle", 32'(nmi_n), 32'h1);
    vbl_pulse(1'b1, 1'b0);
    check("nmi_assert", 32'(nmi_n), 32'h0);
    wr(3'd6, 8'h21);  // leaves w=1
    rd(3'd2, 8'h80, "status_vbl", 1'b0, 1'b0);
    check("nmi_clear", 32'(nmi_n), 32'h1);
    setaddr(8'h22, 8'h10);
    vwr(8'h99, 11'h210, "w_cleared_by_status");
    rd(3'd2, 8'h00, "status_cleared", 1'b0, 1'b0);
    rd(3'd2, 8'h00, "status_set_race", 1'b1, 1'b0);
    check("nmi_after_race", 32'(nmi_n), 32'h0);
    rd(3'd2, 8'h80, "status_after_race", 1'b0, 1'b0);
    vbl_pulse(1'b1, 1'b1);
    rd(3'd2, 8'h00, "set_clr_clr_wins", 1'b0, 1'b0);
    wr(3'd0, 8'h10);
    check("bankbg", 32'(bankbg), 32'h1);

    // Scroll registers and the shared write latch
    wr(3'd5, 8'h7B);
    wr(3'd5, 8'h3C);
    check("scroll_xy", 32'({scroll_x, scroll_y}), 32'({exp_sx, exp_sy}));
    setaddr(8'h21, 8'h00);
    wr(3'd5, 8'h01);   // w=1
    wr(3'd6, 8'h55);   // low byte -> v=$2155
    vwr(8'hE1, 11'h155, "scroll_toggles_w");

    // Strobe while busy is dropped
    wr(3'd0, 8'h00);
    setaddr(8'h24, 8'h00);
    exp_wr_q.push_back({11'h400, 8'hA1});
    exp_wr_n.push_back("busy_first");
    @(posedge clk); #1;
    cpu_a = 3'd7; cpu_din = 8'hA1; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_din = 8'hB2;
    check("busy_in_acc", 32'(busy), 32'h1);
    @(posedge clk); #1;
    cpu_we = 1'b0;
    vwr(8'hC3, 11'h401, "busy_strobe_dropped");

    // Step 32 from $3FF0 wraps to $0010; CHR writes are dropped; walk back into VRAM
    wr(3'd0, 8'h04);
    setaddr(8'h3F, 8'hF0);
    @(posedge clk); #1;
    cpu_a = 3'd7; cpu_din = 8'h3B; cpu_we = 1'b1;
    @(posedge clk); #1;
    cpu_din = 8'h00;   // dropped strobe, must not advance v
    @(posedge clk); #1;
    cpu_we = 1'b0;
    pal_idx = 5'h00; #1;
    check("pal_3ff0_alias", 32'(pal_color), 32'h3B);
    for (int i = 0; i < 256; i++) wr(3'd7, 8'(i));
    vwr(8'hD4, 11'h010, "wrap_walk");

    // Reset in the middle of an access drops wvwe immediately
    wr(3'd0, 8'h00);
    setaddr(8'h20, 8'h40);
    vwr(8'hEE, 11'h040, "pre_reset_write");
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    check("rst_mid_wvwe", 32'(wvwe), 32'h0);
    check("rst_mid_busy", 32'(busy), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (exp_wr_q.size() == 0 && exp_rd_q.size() == 0) break;
      @(posedge clk);
    end
    check("wr_queue_drained", 32'(exp_wr_q.size()), 32'd0);
    check("rd_queue_drained", 32'(exp_rd_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
